match_reporter: RTL

MATCH_REPORTER -- requirements
Module: match_reporter

---
 rtl/match_reporter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/match_reporter.sv
// match_reporter: buffers match boxes in a small FIFO and serializes each one
// as a byte packet (header byte, 8 payload bytes MSB first) over a
// valid/ready byte stream, while keeping per-frame and drop statistics.
// Optional feature: define MATCH_REPORTER_CHECKSUM_EN to append an XOR
// checksum byte after the payload (10-byte packets instead of 9).
module match_reporter #(
  parameter int         DEPTH  = 8,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_frame,
  input  logic        match_flag,
  input  logic [11:0] match_xs,
  input  logic [11:0] match_ys,
  input  logic [11:0] match_xe,
  input  logic [11:0] match_ye,
  input  logic [9:0]  match_span,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  frame_matches,
  output logic [7:0]  drop_count,
  output logic        overflow
);

  localparam int         AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD
`ifdef MATCH_REPORTER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t        state;
  logic [57:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [63:0]   shift;
  logic [2:0]    byte_idx;
`ifdef MATCH_REPORTER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  logic        full;
  logic        pop;
  logic        push;
  logic        drop;
  logic        handshake;
  logic [57:0] entry;

  // The serializer only claims a FIFO entry once the sink is ready, so a
  // stalled sink leaves the full FIFO depth available for buffering.
  assign full      = (count == FULL_LEVEL);
  assign pop       = (state == S_IDLE) && (count != '0) && out_ready;
  assign push      = match_flag && (!full || pop);
  assign drop      = match_flag && full && !pop;
  assign handshake = out_valid && out_ready;
  assign entry     = {match_span, match_xs, match_ys, match_xe, match_ye};

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= entry;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame match counter, drop counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_matches <= '0;
      drop_count    <= '0;
      overflow      <= 1'b0;
    end else begin
      if (new_frame) begin
        frame_matches <= {7'b0, match_flag};
      end else if (match_flag && (frame_matches != 8'hFF)) begin
        frame_matches <= frame_matches + 8'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

  // Packet serializer; out_data/out_valid are registered and only change on
  // a handshake, so they hold steady while the sink stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      shift     <= '0;
      byte_idx  <= '0;
`ifdef MATCH_REPORTER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shift     <= {6'b0, mem[rd_ptr]};
            out_data  <= HEADER;
            out_valid <= 1'b1;
            state     <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (handshake) begin
            out_data <= shift[63:56];
            shift    <= {shift[55:0], 8'h00};
            byte_idx <= '0;
`ifdef MATCH_REPORTER_CHECKSUM_EN
            csum     <= shift[63:56];
`endif
            state    <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (handshake) begin
            if (byte_idx == 3'd7) begin
`ifdef MATCH_REPORTER_CHECKSUM_EN
              out_data  <= csum;
              state     <= S_CSUM;
`else
              out_valid <= 1'b0;
              state     <= S_IDLE;
`endif
            end else begin
              out_data <= shift[63:56];
              shift    <= {shift[55:0], 8'h00};
              byte_idx <= byte_idx + 3'd1;
`ifdef MATCH_REPORTER_CHECKSUM_EN
              csum     <= csum ^ shift[63:56];
`endif
            end
          end
        end
`ifdef MATCH_REPORTER_CHECKSUM_EN
        S_CSUM: begin
          if (handshake) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
`endif
        default: begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
